// File: rtl/sdram_slot_arbiter_if.sv
// Client-side bus of the SDRAM slot arbiter: per-port request bundles plus
// the shared completion and status signals returned to all clients.
interface sdram_slot_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  logic [NUM_PORTS-1:0]    p_req;
  logic [NUM_PORTS-1:0]    p_we;
  logic [NUM_PORTS*20-1:0] p_addr;
  logic [NUM_PORTS*16-1:0] p_din;
  logic [NUM_PORTS*2-1:0]  p_ds;
  logic [NUM_PORTS-1:0]    p_ack;
  logic [15:0]             p_rdata;
  logic                    ready;

  // Client side: drives requests, sees acks, read data and ready.
  modport master (
    output p_req, p_we, p_addr, p_din, p_ds,
    input  p_ack, p_rdata, ready
  );

  // Arbiter side: samples requests, returns acks, read data and ready.
  modport slave (
    input  p_req, p_we, p_addr, p_din, p_ds,
    output p_ack, p_rdata, ready
  );
endinterface

// File: rtl/sdram_slot_arbiter.sv
// Slot sequencer and client arbiter in front of the 8-stage sync-driven
// SDRAM controller. One slot is 8 clocks; each slot serves at most one
// client, and idle slots turn into controller auto-refresh.
module sdram_slot_arbiter #(
  parameter int NUM_PORTS     = 3,
  parameter int ARB_MODE      = 1,
  parameter int REFRESH_EVERY = 8,
  parameter int INIT_SLOTS    = 40
) (
  input  logic                clk,
  input  logic                reset,
  sdram_slot_arbiter_if.slave cl,
  output logic                mem_init,
  output logic                mem_sync,
  output logic [19:0]         mem_addr,
  output logic [15:0]         mem_din,
  output logic [1:0]          mem_ds,
  output logic                mem_oe,
  output logic                mem_we,
  input  logic [15:0]         mem_dout
);

  localparam int PW = 2;
  localparam int SW = $clog2(INIT_SLOTS + 1) + 1;
  localparam int BW = $clog2(REFRESH_EVERY + 1) + 1;

  logic [2:0]           r_cnt;
  logic                 r_sync;
  logic                 r_init;
  logic                 r_ready;
  logic [SW-1:0]        r_slots;
  logic [BW-1:0]        r_busyRun;
  logic [PW-1:0]        r_rrPtr;
  logic                 r_gValid;
  logic [PW-1:0]        r_gPort;
  logic                 r_gWe;
  logic [19:0]          r_addr;
  logic [15:0]          r_din;
  logic [1:0]           r_ds;
  logic                 r_oe;
  logic                 r_we;
  logic [NUM_PORTS-1:0] r_ack;
  logic [15:0]          r_rdata;

  logic                 w_endSlot;
  logic                 w_found;
  logic [PW-1:0]        w_sel;
  logic                 w_forced;
  logic                 w_grant;
  logic                 w_selWe;
  logic [19:0]          w_selAddr;
  logic [15:0]          w_selDin;
  logic [1:0]           w_selDs;

  assign w_endSlot = (r_cnt == 3'd7);
  assign w_forced  = (r_busyRun == BW'(REFRESH_EVERY - 1));
  assign w_grant   = w_found && r_ready && !w_forced;
  assign w_selWe   = cl.p_we[w_sel];
  assign w_selAddr = cl.p_addr[20*int'(w_sel) +: 20];
  assign w_selDin  = cl.p_din[16*int'(w_sel) +: 16];
  assign w_selDs   = cl.p_ds[2*int'(w_sel) +: 2];

  // Pick the candidate port: lowest index in fixed mode, or the first
  // requester after the last granted port in round-robin mode.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (cl.p_req[i]) begin
          w_found = 1'b1;
          w_sel   = PW'(i);
        end
      end
    end else begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        if (cl.p_req[(int'(r_rrPtr) + k) % NUM_PORTS]) begin
          w_found = 1'b1;
          w_sel   = PW'((int'(r_rrPtr) + k) % NUM_PORTS);
        end
      end
    end
  end

  // Slot timing, init tracking, grant/refresh bookkeeping and the
  // controller command registers; everything slot-level moves on the edge ending cnt7.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 3'd0;
      r_sync    <= 1'b0;
      r_init    <= 1'b1;
      r_ready   <= 1'b0;
      r_slots   <= '0;
      r_busyRun <= '0;
      r_rrPtr   <= PW'(NUM_PORTS - 1);
      r_gValid  <= 1'b0;
      r_gPort   <= '0;
      r_gWe     <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_ds      <= '0;
      r_oe      <= 1'b0;
      r_we      <= 1'b0;
      r_ack     <= '0;
      r_rdata   <= '0;
    end else begin
      r_cnt  <= r_cnt + 3'd1;
      r_sync <= (r_cnt == 3'd7) || (r_cnt < 3'd3);
      r_init <= 1'b0;
      r_ack  <= '0;
      if (w_endSlot) begin
        if (r_gValid) begin
          r_ack[r_gPort] <= 1'b1;
          if (!r_gWe) begin
            r_rdata <= mem_dout;
          end
        end
        if (!r_ready) begin
          r_slots <= r_slots + SW'(1);
          if (r_slots == SW'(INIT_SLOTS - 1)) begin
            r_ready <= 1'b1;
          end
        end
        r_gValid <= w_grant;
        r_gPort  <= w_sel;
        r_gWe    <= w_selWe;
        if (w_grant) begin
          r_busyRun <= r_busyRun + BW'(1);
          r_addr    <= w_selAddr;
          r_din     <= w_selDin;
          r_ds      <= w_selDs;
          r_oe      <= !w_selWe;
          r_we      <= w_selWe;
          if (ARB_MODE != 0) begin
            r_rrPtr <= w_sel;
          end
        end else begin
          r_busyRun <= '0;
          r_addr    <= '0;
          r_din     <= '0;
          r_ds      <= '0;
          r_oe      <= 1'b0;
          r_we      <= 1'b0;
        end
      end
    end
  end

  assign mem_init   = r_init;
  assign mem_sync   = r_sync;
  assign mem_addr   = r_addr;
  assign mem_din    = r_din;
  assign mem_ds     = r_ds;
  assign mem_oe     = r_oe;
  assign mem_we     = r_we;
  assign cl.p_ack   = r_ack;
  assign cl.p_rdata = r_rdata;
  assign cl.ready   = r_ready;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter: a round-robin instance (A) and a
// fixed-priority instance (B) share clock, reset and the memory data model.
module tb_sdram_slot_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] memDout = 16'hDEAD;

  logic        initA, syncA, oeA, weA;
  logic [19:0] addrA;
  logic [15:0] dinA;
  logic [1:0]  dsA;
  logic        initB, syncB, oeB, weB;
  logic [19:0] addrB;
  logic [15:0] dinB;
  logic [1:0]  dsB;

  int edges = 0;
  int testCount = 0;
  int failCount = 0;

  typedef struct {
    int          port;
    logic        we;
    logic [19:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
    logic [15:0] dout;
    logic        expOe;
    logic        expWe;
    logic [2:0]  expAck;
    logic [15:0] expRdata;
  } vec_t;

  vec_t vecs[5];
  int rrGrant[16] = '{1, 2, 0, 1, 2, 0, 1, -1, 2, 0, 1, 2, 0, 1, 2, -1};
  int fpGrant[16] = '{0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, -1};

  sdram_slot_arbiter_if #(.NUM_PORTS(3)) busA ();
  sdram_slot_arbiter_if #(.NUM_PORTS(3)) busB ();

  sdram_slot_arbiter #(.NUM_PORTS(3), .ARB_MODE(1), .REFRESH_EVERY(8), .INIT_SLOTS(40)) dutA (
    .clk(clk), .reset(reset), .cl(busA),
    .mem_init(initA), .mem_sync(syncA), .mem_addr(addrA), .mem_din(dinA),
    .mem_ds(dsA), .mem_oe(oeA), .mem_we(weA), .mem_dout(memDout)
  );

  sdram_slot_arbiter #(.NUM_PORTS(3), .ARB_MODE(0), .REFRESH_EVERY(8), .INIT_SLOTS(40)) dutB (
    .clk(clk), .reset(reset), .cl(busB),
    .mem_init(initB), .mem_sync(syncB), .mem_addr(addrB), .mem_din(dinB),
    .mem_ds(dsB), .mem_oe(oeB), .mem_we(weB), .mem_dout(memDout)
  );

  always #5 clk = ~clk;

  // Bench-side count of clock edges since reset release, giving the slot phase.
  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic toPhase(input int p);
    nextCycle();
    for (int i = 0; i < 8 && (edges % 8) != p; i++) nextCycle();
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [19:0] addr, input logic [15:0] din, input logic [1:0] ds);
    busA.p_req[port]           = req;
    busA.p_we[port]            = we;
    busA.p_addr[20*port +: 20] = addr;
    busA.p_din[16*port +: 16]  = din;
    busA.p_ds[2*port +: 2]     = ds;
  endtask

  function automatic logic [2:0] ackMask(input int g);
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  // Called right after reset release: reset values, sync waveform, 40-slot init.
  task automatic runInit(input string tag);
    logic badCmd;
    badCmd = 1'b0;
    checkOutput({tag, " rst sync"},  32'(syncA),        32'h0);
    checkOutput({tag, " rst oe"},    32'(oeA),          32'h0);
    checkOutput({tag, " rst we"},    32'(weA),          32'h0);
    checkOutput({tag, " rst addr"},  32'(addrA),        32'h0);
    checkOutput({tag, " rst din"},   32'(dinA),         32'h0);
    checkOutput({tag, " rst ds"},    32'(dsA),          32'h0);
    checkOutput({tag, " rst ack"},   32'(busA.p_ack),   32'h0);
    checkOutput({tag, " rst rdata"}, 32'(busA.p_rdata), 32'h0);
    checkOutput({tag, " rst ready"}, 32'(busA.ready),   32'h0);
    checkOutput({tag, " rst init"},  32'(initA),        32'h1);
    checkOutput({tag, " rst initB"}, 32'(initB),        32'h1);
    while (edges < 319) begin
      nextCycle();
      if (edges <= 16) begin
        checkOutput($sformatf("%s sync e%0d", tag, edges), 32'(syncA), 32'((edges % 8) < 4));
      end
      if (edges == 1) checkOutput({tag, " init drop"}, 32'(initA), 32'h0);
      if (oeA || weA || oeB || weB || (busA.p_ack != 0) || (busB.p_ack != 0)) badCmd = 1'b1;
    end
    checkOutput({tag, " idle no cmd/ack"}, 32'(badCmd), 32'h0);
    checkOutput({tag, " ready e319"},  32'(busA.ready), 32'h0);
    checkOutput({tag, " readyB e319"}, 32'(busB.ready), 32'h0);
    nextCycle();
    checkOutput({tag, " ready e320"},  32'(busA.ready), 32'h1);
    checkOutput({tag, " readyB e320"}, 32'(busB.ready), 32'h1);
  endtask

  initial begin
    logic [2:0] expAckA;
    logic [2:0] expAckB;
    int prevA;
    int prevB;

    vecs[0] = '{1, 1'b0, 20'h12345, 16'h0000, 2'b11, 16'hBEEF, 1'b1, 1'b0, 3'b010, 16'hBEEF};
    vecs[1] = '{0, 1'b1, 20'h00F00, 16'hA5A5, 2'b01, 16'h1111, 1'b0, 1'b1, 3'b001, 16'hBEEF};
    vecs[2] = '{2, 1'b0, 20'hFFFFF, 16'h0000, 2'b11, 16'h0F0F, 1'b1, 1'b0, 3'b100, 16'h0F0F};
    vecs[3] = '{2, 1'b1, 20'h00000, 16'hFFFF, 2'b10, 16'h2222, 1'b0, 1'b1, 3'b100, 16'h0F0F};
    vecs[4] = '{0, 1'b0, 20'hABCDE, 16'h1234, 2'b11, 16'h5A5A, 1'b1, 1'b0, 3'b001, 16'h5A5A};

    busA.p_req = '0; busA.p_we = '0; busA.p_addr = '0; busA.p_din = '0; busA.p_ds = '0;
    busB.p_req = '0; busB.p_we = '0; busB.p_addr = '0; busB.p_din = '0; busB.p_ds = '0;

    reset = 1'b1;
    repeat (3) nextCycle();
    reset = 1'b0;
    runInit("init");

    // Single transactions on the round-robin instance.
    for (int v = 0; v < 5; v++) begin
      toPhase(1);
      applyStimulus(vecs[v].port, 1'b1, vecs[v].we, vecs[v].addr, vecs[v].din, vecs[v].ds);
      toPhase(0);
      checkOutput($sformatf("v%0d ack before", v), 32'(busA.p_ack), 32'h0);
      for (int ph = 0; ph < 8; ph++) begin
        checkOutput($sformatf("v%0d ph%0d oe", v, ph),   32'(oeA),   32'(vecs[v].expOe));
        checkOutput($sformatf("v%0d ph%0d we", v, ph),   32'(weA),   32'(vecs[v].expWe));
        checkOutput($sformatf("v%0d ph%0d addr", v, ph), 32'(addrA), 32'(vecs[v].addr));
        checkOutput($sformatf("v%0d ph%0d din", v, ph),  32'(dinA),  32'(vecs[v].din));
        checkOutput($sformatf("v%0d ph%0d ds", v, ph),   32'(dsA),   32'(vecs[v].ds));
        if (ph == 3) begin
          applyStimulus(vecs[v].port, 1'b0, ~vecs[v].we, ~vecs[v].addr, ~vecs[v].din, ~vecs[v].ds);
        end
        if (ph == 7) memDout = vecs[v].dout;
        if (ph < 7) nextCycle();
      end
      nextCycle();
      memDout = 16'hDEAD;
      checkOutput($sformatf("v%0d ack", v),   32'(busA.p_ack),   32'(vecs[v].expAck));
      checkOutput($sformatf("v%0d rdata", v), 32'(busA.p_rdata), 32'(vecs[v].expRdata));
      nextCycle();
      checkOutput($sformatf("v%0d ack pulse end", v), 32'(busA.p_ack), 32'h0);
      checkOutput($sformatf("v%0d rdata held", v),    32'(busA.p_rdata), 32'(vecs[v].expRdata));
    end

    // Contention: A has all three ports reading, B has ports 0 and 2 reading.
    toPhase(1);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(p, 1'b1, 1'b0, 20'h10000 + 20'(p), 16'h0, 2'b11);
    end
    busB.p_req = 3'b101;
    busB.p_we  = 3'b000;
    busB.p_addr = {20'h20002, 20'h20001, 20'h20000};
    busB.p_ds   = 6'b111111;
    toPhase(0);
    prevA = -1;
    prevB = -1;
    for (int s = 0; s < 16; s++) begin
      expAckA = ackMask(prevA);
      expAckB = ackMask(prevB);
      checkOutput($sformatf("rr s%0d oe", s),  32'(oeA), 32'(rrGrant[s] >= 0));
      checkOutput($sformatf("rr s%0d ack", s), 32'(busA.p_ack), 32'(expAckA));
      if (rrGrant[s] >= 0) checkOutput($sformatf("rr s%0d addr", s), 32'(addrA), 32'h10000 + 32'(rrGrant[s]));
      checkOutput($sformatf("fp s%0d oe", s),  32'(oeB), 32'(fpGrant[s] >= 0));
      checkOutput($sformatf("fp s%0d ack", s), 32'(busB.p_ack), 32'(expAckB));
      if (fpGrant[s] >= 0) checkOutput($sformatf("fp s%0d addr", s), 32'(addrB), 32'h20000);
      prevA = rrGrant[s];
      prevB = fpGrant[s];
      if (s == 15) begin
        busA.p_req = '0;
        busB.p_req = '0;
      end
      toPhase(0);
    end
    checkOutput("rr tail ack", 32'(busA.p_ack), 32'h0);
    checkOutput("fp tail ack", 32'(busB.p_ack), 32'h0);
    checkOutput("rr tail oe",  32'(oeA), 32'h0);

    // Reset in the middle of a granted read slot.
    toPhase(1);
    applyStimulus(1, 1'b1, 1'b0, 20'h13579, 16'h0, 2'b11);
    toPhase(0);
    checkOutput("rst-mid granted oe", 32'(oeA), 32'h1);
    toPhase(4);
    reset = 1'b1;
    nextCycle();
    checkOutput("rst-mid oe",    32'(oeA),        32'h0);
    checkOutput("rst-mid addr",  32'(addrA),      32'h0);
    checkOutput("rst-mid init",  32'(initA),      32'h1);
    checkOutput("rst-mid sync",  32'(syncA),      32'h0);
    checkOutput("rst-mid ready", 32'(busA.ready), 32'h0);
    checkOutput("rst-mid ack",   32'(busA.p_ack), 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 20'h0, 16'h0, 2'b00);
    memDout = 16'h7777;
    nextCycle();
    reset = 1'b0;
    runInit("reinit");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
